morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder.sv | 182 ++++++++++++++++++
 tb/tb_morse_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Tick-driven Morse decoder: classifies marks as dots/dashes and emits up to 5-element symbols.
// Optional word-boundary pulse is enabled by defining MORSE_WORD_GAP_EN.
module morse_decoder #(
  parameter int unsigned DOT_MAX  = 2,
  parameter int unsigned CHAR_GAP = 3,
  parameter int unsigned WORD_GAP = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_in,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_len,
  output logic       sym_valid,
  output logic       err,
  output logic       busy,
  output logic       word_gap
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, ERR} state_e;

  state_e     state_q, state_d;
  logic [2:0] mark_cnt_q, mark_cnt_d;
  logic [2:0] space_cnt_q, space_cnt_d;
  logic [2:0] elem_cnt_q, elem_cnt_d;
  logic [4:0] buf_q, buf_d;
  logic [4:0] sym_bits_q, sym_bits_d;
  logic [2:0] sym_len_q, sym_len_d;
  logic       sym_valid_q, sym_valid_d;
  logic       err_q, err_d;
  logic       is_dash;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign is_dash = (32'(mark_cnt_q) > DOT_MAX);

  always_comb begin
    state_d     = state_q;
    mark_cnt_d  = mark_cnt_q;
    space_cnt_d = space_cnt_q;
    elem_cnt_d  = elem_cnt_q;
    buf_d       = buf_q;
    sym_bits_d  = sym_bits_q;
    sym_len_d   = sym_len_q;
    sym_valid_d = 1'b0;
    err_d       = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (key_in) begin
            state_d    = MARK;
            mark_cnt_d = 3'd1;
          end
        end
        MARK: begin
          if (key_in) begin
            mark_cnt_d = sat_inc(mark_cnt_q);
          end else if (elem_cnt_q == 3'd5) begin
            // Sixth element: drop the whole symbol; the ending low tick already counts toward recovery.
            err_d       = 1'b1;
            buf_d       = '0;
            elem_cnt_d  = '0;
            space_cnt_d = 3'd1;
            state_d     = ERR;
          end else begin
            buf_d       = buf_q | (5'(is_dash) << elem_cnt_q);
            elem_cnt_d  = elem_cnt_q + 3'd1;
            space_cnt_d = 3'd1;
            state_d     = SPACE;
          end
        end
        SPACE: begin
          if (key_in) begin
            state_d    = MARK;
            mark_cnt_d = 3'd1;
          end else begin
            space_cnt_d = sat_inc(space_cnt_q);
            if (32'(sat_inc(space_cnt_q)) >= CHAR_GAP) begin
              sym_bits_d  = buf_q;
              sym_len_d   = elem_cnt_q;
              sym_valid_d = 1'b1;
              buf_d       = '0;
              elem_cnt_d  = '0;
              space_cnt_d = '0;
              state_d     = IDLE;
            end
          end
        end
        ERR: begin
          if (key_in) begin
            space_cnt_d = '0;
          end else begin
            space_cnt_d = sat_inc(space_cnt_q);
            if (32'(sat_inc(space_cnt_q)) >= CHAR_GAP) begin
              space_cnt_d = '0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mark_cnt_q  <= '0;
      space_cnt_q <= '0;
      elem_cnt_q  <= '0;
      buf_q       <= '0;
      sym_bits_q  <= '0;
      sym_len_q   <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mark_cnt_q  <= mark_cnt_d;
      space_cnt_q <= space_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      buf_q       <= buf_d;
      sym_bits_q  <= sym_bits_d;
      sym_len_q   <= sym_len_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
    end
  end

  assign sym_bits  = sym_bits_q;
  assign sym_len   = sym_len_q;
  assign sym_valid = sym_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

`ifdef MORSE_WORD_GAP_EN
  logic [2:0] wg_cnt_q, wg_cnt_d;
  logic       wg_arm_q, wg_arm_d;
  logic       word_gap_q, word_gap_d;
  logic       elem_store;

  // An element is stored exactly when a mark ends without overflowing.
  assign elem_store = tick && (state_q == MARK) && !key_in && !err_d;

  always_comb begin
    wg_cnt_d   = wg_cnt_q;
    wg_arm_d   = wg_arm_q;
    word_gap_d = 1'b0;
    if (elem_store) begin
      wg_cnt_d = 3'd1;
      wg_arm_d = 1'b1;
    end else if (tick && (key_in || err_d)) begin
      wg_cnt_d = '0;
      wg_arm_d = 1'b0;
    end else if (tick && wg_arm_q) begin
      wg_cnt_d = sat_inc(wg_cnt_q);
      if (32'(sat_inc(wg_cnt_q)) >= WORD_GAP) begin
        word_gap_d = 1'b1;
        wg_arm_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wg_cnt_q   <= '0;
      wg_arm_q   <= 1'b0;
      word_gap_q <= 1'b0;
    end else begin
      wg_cnt_q   <= wg_cnt_d;
      wg_arm_q   <= wg_arm_d;
      word_gap_q <= word_gap_d;
    end
  end

  assign word_gap = word_gap_q;
`else
  assign word_gap = (WORD_GAP == 32'd0) && 1'b0;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed letter scenarios plus randomized key streams
// compared against a run-length reference model of the decoding rules.
module tb_morse_decoder;
  localparam int unsigned DOT_MAX  = 2;
  localparam int unsigned CHAR_GAP = 3;
  localparam int unsigned WORD_GAP = 7;

  logic       clk = 1'b0;
  logic       reset, tick, key_in;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       sym_valid, err, busy, word_gap;

  morse_decoder #(.DOT_MAX(DOT_MAX), .CHAR_GAP(CHAR_GAP), .WORD_GAP(WORD_GAP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_in(key_in),
    .sym_bits(sym_bits), .sym_len(sym_len), .sym_valid(sym_valid),
    .err(err), .busy(busy), .word_gap(word_gap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int gap_pulses = 0;

  // Reference model: tracks the current mark length, the low-run length and the element list.
  bit         m_in_mark, m_in_err, m_wg_armed;
  int         m_mark_len, m_low_run, m_wg_run;
  bit         m_elems[$];
  bit         m_valid, m_err, m_wg;
  logic [4:0] m_bits;
  logic [2:0] m_len;

  function automatic bit m_busy();
    return m_in_mark || m_in_err || (m_elems.size() != 0);
  endfunction

  task automatic model_reset();
    m_in_mark = 0; m_in_err = 0; m_wg_armed = 0;
    m_mark_len = 0; m_low_run = 0; m_wg_run = 0;
    m_elems.delete();
    m_valid = 0; m_err = 0; m_wg = 0;
    m_bits = '0; m_len = '0;
  endtask

  task automatic model_step(input bit k);
    m_valid = 0; m_err = 0; m_wg = 0;
    if (k) begin
      m_wg_armed = 0;
      if (m_in_err) m_low_run = 0;
      else if (m_in_mark) m_mark_len++;
      else begin m_in_mark = 1; m_mark_len = 1; end
    end else if (m_in_mark) begin
      m_in_mark = 0;
      m_low_run = 1;
      if (m_elems.size() == 5) begin
        m_err = 1; m_elems.delete(); m_in_err = 1; m_wg_armed = 0;
      end else begin
        m_elems.push_back(m_mark_len > DOT_MAX);
        m_wg_armed = 1; m_wg_run = 1;
      end
    end else begin
      m_low_run++;
      if (m_in_err) begin
        if (m_low_run >= CHAR_GAP) m_in_err = 0;
      end else if (m_elems.size() != 0 && m_low_run == CHAR_GAP) begin
        m_bits = '0;
        foreach (m_elems[i]) m_bits[i] = m_elems[i];
        m_len = 3'(m_elems.size());
        m_valid = 1;
        m_elems.delete();
      end
      if (m_wg_armed) begin
        m_wg_run++;
        if (m_wg_run == WORD_GAP) begin
          m_wg_armed = 0;
`ifdef MORSE_WORD_GAP_EN
          m_wg = 1;
`endif
        end
      end
    end
  endtask

  // Drives `gap` idle cycles (key toggling freely) then one tick with key=k; samples #1 after the edge.
  task automatic do_tick(input bit k, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); tick = 1'b0; key_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (sym_valid || err || word_gap) gap_pulses++;
      if (busy !== m_busy()) gap_pulses++;
    end
    @(negedge clk); tick = 1'b1; key_in = k;
    @(posedge clk); model_step(k); #1;
  endtask

  int         obs_nvalid, obs_nerr, obs_nwg, obs_vtick, obs_wtick;
  logic [4:0] obs_bits;
  logic [2:0] obs_len;

  // Plays alternating runs starting with a mark and records what the outputs did.
  task automatic play(input int runs[$], input int gap);
    bit k = 1'b1;
    int idx = 0;
    obs_nvalid = 0; obs_nerr = 0; obs_nwg = 0; obs_vtick = -1; obs_wtick = -1;
    obs_bits = 'x; obs_len = 'x;
    foreach (runs[r]) begin
      for (int n = 0; n < runs[r]; n++) begin
        do_tick(k, gap);
        idx++;
        if (sym_valid) begin obs_nvalid++; obs_bits = sym_bits; obs_len = sym_len; obs_vtick = idx; end
        if (err) obs_nerr++;
        if (word_gap) begin obs_nwg++; obs_wtick = idx; end
      end
      k = !k;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b1; key_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sym_bits, sym_len, sym_valid, err, busy, word_gap} !== 12'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {sym_bits, sym_len, sym_valid, err, busy, word_gap}, 12'b0);
    end
    @(negedge clk); reset = 1'b0; tick = 1'b0; key_in = 1'b0;
  endtask

  task automatic test_letters();
    int runs[$];
    runs = '{1, 1, 3, 3};
    play(runs, 1);
    checks++;
    if (obs_nvalid !== 1 || obs_bits !== 5'b00010 || obs_len !== 3'd2) begin
      errors++;
      $display("FAIL letter_A: got n=%0d bits=%b len=%0d want n=1 bits=00010 len=2", obs_nvalid, obs_bits, obs_len);
    end
    checks++;
    if (obs_vtick !== 8) begin
      errors++;
      $display("FAIL latency_A: got valid at tick %0d want 8", obs_vtick);
    end
    runs = '{3, 3};
    play(runs, 2);
    checks++;
    if (obs_nvalid !== 1 || obs_bits !== 5'b00001 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL letter_T: got n=%0d bits=%b len=%0d want n=1 bits=00001 len=1", obs_nvalid, obs_bits, obs_len);
    end
    runs = '{2, 3};
    play(runs, 1);
    checks++;
    if (obs_bits !== 5'b00000 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL mark2_dot: got bits=%b len=%0d want bits=00000 len=1", obs_bits, obs_len);
    end
    runs = '{9, 3};
    play(runs, 1);
    checks++;
    if (obs_bits !== 5'b00001 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL mark9_dash: got bits=%b len=%0d want bits=00001 len=1", obs_bits, obs_len);
    end
    checks++;
    if (sym_bits !== 5'b00001 || sym_len !== 3'd1) begin
      errors++;
      $display("FAIL sym_hold: got bits=%b len=%0d want bits=00001 len=1", sym_bits, sym_len);
    end
  endtask

  task automatic test_overflow();
    int runs[$];
    runs = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 4};
    play(runs, 1);
    checks++;
    if (obs_nerr !== 1 || obs_nvalid !== 0) begin
      errors++;
      $display("FAIL overflow: got err=%0d valid=%0d want err=1 valid=0", obs_nerr, obs_nvalid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tick = 1'b0; key_in = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b1; key_in = 1'b0;
      @(posedge clk); model_step(1'b0); #1;
      checks++;
      if (busy !== 1'b0 || sym_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch_%0d: got busy=%b valid=%b want 0 0", i, busy, sym_valid);
      end
    end
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic test_word_gap();
    int runs[$];
    runs = '{1, 7};
    play(runs, 1);
    checks++;
    if (obs_nvalid !== 1 || obs_vtick !== 4 || obs_bits !== 5'b0 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL wg_letter_E: got n=%0d tick=%0d bits=%b len=%0d want n=1 tick=4 bits=0 len=1",
               obs_nvalid, obs_vtick, obs_bits, obs_len);
    end
`ifdef MORSE_WORD_GAP_EN
    checks++;
    if (obs_nwg !== 1 || obs_wtick !== 8) begin
      errors++;
      $display("FAIL word_gap_pulse: got n=%0d tick=%0d want n=1 tick=8", obs_nwg, obs_wtick);
    end
`else
    checks++;
    if (obs_nwg !== 0) begin
      errors++;
      $display("FAIL word_gap_off: got %0d pulses want 0", obs_nwg);
    end
`endif
    runs = '{1, 5, 1, 3};
    play(runs, 1);
    checks++;
    if (obs_nwg !== 0 || obs_nvalid !== 2) begin
      errors++;
      $display("FAIL word_gap_cancel: got wg=%0d valid=%0d want wg=0 valid=2", obs_nwg, obs_nvalid);
    end
  endtask

  task automatic test_back_to_back();
    int runs[$];
    runs = '{1, 1, 3, 3, 3, 3};
    play(runs, 0);
    checks++;
    if (obs_nvalid !== 2 || obs_bits !== 5'b00001 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL back_to_back: got n=%0d bits=%b len=%0d want n=2 bits=00001 len=1", obs_nvalid, obs_bits, obs_len);
    end
  endtask

  task automatic test_reset_mid();
    int runs[$];
    runs = '{1, 1, 2};
    play(runs, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({sym_bits, sym_len, sym_valid, err, busy, word_gap} !== 12'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b want %b", {sym_bits, sym_len, sym_valid, err, busy, word_gap}, 12'b0);
    end
    @(negedge clk); tick = 1'b1; key_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dominates: got busy=%b valid=%b want 0 0", busy, sym_valid);
    end
    @(negedge clk); reset = 1'b0; tick = 1'b0; key_in = 1'b0;
    runs = '{1, 3};
    play(runs, 1);
    checks++;
    if (obs_nvalid !== 1 || obs_bits !== 5'b0 || obs_len !== 3'd1) begin
      errors++;
      $display("FAIL after_reset_E: got n=%0d bits=%b len=%0d want n=1 bits=0 len=1", obs_nvalid, obs_bits, obs_len);
    end
  endtask

  task automatic test_random();
    logic [11:0] act, exp;
    bit k = 1'b1;
    int len;
    gap_pulses = 0;
    for (int r = 0; r < 160; r++) begin
      if (k) len = $urandom_range(1, 9);
      else len = ($urandom_range(0, 1) != 0) ? 1 : $urandom_range(1, 9);
      if (r == 159) len = 10;
      for (int n = 0; n < len; n++) begin
        do_tick(k, $urandom_range(0, 2));
        act = {sym_valid, err, word_gap, busy, sym_bits, sym_len};
        exp = {m_valid, m_err, m_wg, m_busy(), m_bits, m_len};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL random_r%0d_t%0d: got v/e/w/b/bits/len=%b want %b", r, n, act, exp);
        end
      end
      k = !k;
    end
    checks++;
    if (gap_pulses !== 0) begin
      errors++;
      $display("FAIL between_ticks: got %0d stray pulses/state changes want 0", gap_pulses);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_letters();
    test_overflow();
    test_glitch();
    test_word_gap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
